// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB-to-ID operand bypass, load-use stall
// detection, flush handling and a saturating stall counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 10
) (
  input  logic              i_CLK,
  input  logic              i_RSTn,
  input  logic              i_Valid,
  input  logic [31:0]       i_Instr,
  input  logic [DATA_W-1:0] i_PC_Plus4,
  input  logic [CTRL_W-1:0] i_Ctrl,
  input  logic [DATA_W-1:0] i_Read_Reg_Data1,
  input  logic [DATA_W-1:0] i_Read_Reg_Data2,
  input  logic              i_WB_RegWrite,
  input  logic [4:0]        i_WB_Write_Reg_Addr,
  input  logic [DATA_W-1:0] i_WB_Write_Reg_Data,
  input  logic              i_Flush,
  output logic              o_Stall,
  output logic              o_EX_Valid,
  output logic [CTRL_W-1:0] o_EX_Ctrl,
  output logic [DATA_W-1:0] o_EX_PC_Plus4,
  output logic [DATA_W-1:0] o_EX_Read_Data1,
  output logic [DATA_W-1:0] o_EX_Read_Data2,
  output logic [DATA_W-1:0] o_EX_Imm,
  output logic [4:0]        o_EX_Rs,
  output logic [4:0]        o_EX_Rt,
  output logic [4:0]        o_EX_Rd,
  output logic [4:0]        o_EX_Shamt,
  output logic [15:0]       o_Stall_Cnt
);

  localparam int MEMRD = 8;

  typedef enum logic {RUN, BUBBLE} state_t;

  typedef struct packed {
    logic              vld;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        sh;
  } ex_t;

  state_t      state, state_nxt;
  ex_t         ex_q, ex_d;
  logic [4:0]  rs, rt;
  logic [DATA_W-1:0] op1, op2;
  logic        hazard, stall;
  logic [15:0] stall_cnt;

  assign rs = i_Instr[25:21];
  assign rt = i_Instr[20:16];

  // r0 reads as zero; a nonzero match against WB forwards the in-flight write
  always_comb begin
    op1 = i_Read_Reg_Data1;
    op2 = i_Read_Reg_Data2;
    if (rs == 5'd0) op1 = '0;
    else if (i_WB_RegWrite && i_WB_Write_Reg_Addr == rs) op1 = i_WB_Write_Reg_Data;
    if (rt == 5'd0) op2 = '0;
    else if (i_WB_RegWrite && i_WB_Write_Reg_Addr == rt) op2 = i_WB_Write_Reg_Data;
  end

  assign hazard = ex_q.vld && ex_q.ctrl[MEMRD] && (ex_q.rt != 5'd0) && i_Valid &&
                  ((ex_q.rt == rs) || (ex_q.rt == rt));
  assign stall  = hazard && !i_Flush;
  assign o_Stall = stall;

  always_comb begin
    ex_d = '0;
    if (i_Valid && !i_Flush && !stall) begin
      ex_d.vld  = 1'b1;
      ex_d.ctrl = i_Ctrl;
      ex_d.pc   = i_PC_Plus4;
      ex_d.d1   = op1;
      ex_d.d2   = op2;
      ex_d.imm  = {{(DATA_W-16){i_Instr[15]}}, i_Instr[15:0]};
      ex_d.rs   = rs;
      ex_d.rt   = rt;
      ex_d.rd   = i_Instr[15:11];
      ex_d.sh   = i_Instr[10:6];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (stall) state_nxt = BUBBLE;
      BUBBLE:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (i_Flush) state_nxt = RUN;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state     <= RUN;
      ex_q      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      ex_q  <= ex_d;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // The bubble loaded on a stall clears the hazard, so BUBBLE never stalls
  a_no_double_stall: assert property (@(posedge i_CLK) disable iff (!i_RSTn)
    !(state == BUBBLE && o_Stall));

  assign o_EX_Valid      = ex_q.vld;
  assign o_EX_Ctrl       = ex_q.ctrl;
  assign o_EX_PC_Plus4   = ex_q.pc;
  assign o_EX_Read_Data1 = ex_q.d1;
  assign o_EX_Read_Data2 = ex_q.d2;
  assign o_EX_Imm        = ex_q.imm;
  assign o_EX_Rs         = ex_q.rs;
  assign o_EX_Rt         = ex_q.rt;
  assign o_EX_Rd         = ex_q.rd;
  assign o_EX_Shamt      = ex_q.sh;
  assign o_Stall_Cnt     = stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;

  logic        i_CLK = 1'b0;
  logic        i_RSTn, i_Valid, i_WB_RegWrite, i_Flush;
  logic [31:0] i_Instr, i_PC_Plus4, i_Read_Reg_Data1, i_Read_Reg_Data2, i_WB_Write_Reg_Data;
  logic [9:0]  i_Ctrl;
  logic [4:0]  i_WB_Write_Reg_Addr;
  logic        o_Stall, o_EX_Valid;
  logic [9:0]  o_EX_Ctrl;
  logic [31:0] o_EX_PC_Plus4, o_EX_Read_Data1, o_EX_Read_Data2, o_EX_Imm;
  logic [4:0]  o_EX_Rs, o_EX_Rt, o_EX_Rd, o_EX_Shamt;
  logic [15:0] o_Stall_Cnt;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  id_ex_stage #(.DATA_W(32), .CTRL_W(10)) dut (
    .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_Valid(i_Valid), .i_Instr(i_Instr),
    .i_PC_Plus4(i_PC_Plus4), .i_Ctrl(i_Ctrl),
    .i_Read_Reg_Data1(i_Read_Reg_Data1), .i_Read_Reg_Data2(i_Read_Reg_Data2),
    .i_WB_RegWrite(i_WB_RegWrite), .i_WB_Write_Reg_Addr(i_WB_Write_Reg_Addr),
    .i_WB_Write_Reg_Data(i_WB_Write_Reg_Data), .i_Flush(i_Flush),
    .o_Stall(o_Stall), .o_EX_Valid(o_EX_Valid), .o_EX_Ctrl(o_EX_Ctrl),
    .o_EX_PC_Plus4(o_EX_PC_Plus4), .o_EX_Read_Data1(o_EX_Read_Data1),
    .o_EX_Read_Data2(o_EX_Read_Data2), .o_EX_Imm(o_EX_Imm), .o_EX_Rs(o_EX_Rs),
    .o_EX_Rt(o_EX_Rt), .o_EX_Rd(o_EX_Rd), .o_EX_Shamt(o_EX_Shamt),
    .o_Stall_Cnt(o_Stall_Cnt)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_vld;
  logic [9:0]  m_ctrl;
  logic [31:0] m_pc, m_d1, m_d2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd, m_sh;
  logic [15:0] m_cnt = '0;

  function automatic bit exp_stall();
    logic [4:0] s = i_Instr[25:21];
    logic [4:0] t = i_Instr[20:16];
    bit load_in_ex = m_vld && m_ctrl[8] && m_rt != 0;
    return load_in_ex && i_Valid && (m_rt == s || m_rt == t) && !i_Flush;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'h0;
    if (i_WB_RegWrite && i_WB_Write_Reg_Addr == r) return i_WB_Write_Reg_Data;
    return rf;
  endfunction

  always @(posedge i_CLK) begin
    bit st;
    shortint simm;
    st = exp_stall();
    if (!i_RSTn) m_cnt = 0;
    else if (st) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
    {m_vld, m_ctrl, m_pc, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd, m_sh} = '0;
    if (i_RSTn && i_Valid && !i_Flush && !st) begin
      simm   = i_Instr[15:0];
      m_vld  = 1;
      m_ctrl = i_Ctrl;
      m_pc   = i_PC_Plus4;
      m_d1   = opnd(i_Instr[25:21], i_Read_Reg_Data1);
      m_d2   = opnd(i_Instr[20:16], i_Read_Reg_Data2);
      m_imm  = 32'(int'(simm));
      m_rs   = i_Instr[25:21];
      m_rt   = i_Instr[20:16];
      m_rd   = i_Instr[15:11];
      m_sh   = i_Instr[10:6];
    end
  end

  // Compare process: outputs are stable mid-cycle
  always @(negedge i_CLK) begin
    if (check_en) begin
      chk("m_stall", 64'(o_Stall), 64'(exp_stall()));
      chk("m_valid", 64'(o_EX_Valid), 64'(m_vld));
      chk("m_ctrl",  64'(o_EX_Ctrl), 64'(m_ctrl));
      chk("m_pc",    64'(o_EX_PC_Plus4), 64'(m_pc));
      chk("m_d1",    64'(o_EX_Read_Data1), 64'(m_d1));
      chk("m_d2",    64'(o_EX_Read_Data2), 64'(m_d2));
      chk("m_imm",   64'(o_EX_Imm), 64'(m_imm));
      chk("m_regs",  64'({o_EX_Rs, o_EX_Rt, o_EX_Rd, o_EX_Shamt}), 64'({m_rs, m_rt, m_rd, m_sh}));
      chk("m_cnt",   64'(o_Stall_Cnt), 64'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] LW   = 32'h8C850004; // lw  $5,4($4)
  localparam logic [31:0] ADD  = 32'h00A73020; // add $6,$5,$7
  localparam logic [31:0] ADD0 = 32'h00A03020; // add $6,$5,$0

  task automatic cyc();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [9:0] ctrl);
    i_Valid = 1;
    i_Instr = ins;
    i_Ctrl  = ctrl;
  endtask

  initial begin
    i_RSTn = 0; i_Valid = 0; i_Instr = 0; i_PC_Plus4 = 0; i_Ctrl = 0;
    i_Read_Reg_Data1 = 0; i_Read_Reg_Data2 = 0; i_WB_RegWrite = 0;
    i_WB_Write_Reg_Addr = 0; i_WB_Write_Reg_Data = 0; i_Flush = 0;
    cyc(); cyc();
    check_en = 1;
    chk("rst_stall", 64'(o_Stall), 0);
    chk("rst_valid", 64'(o_EX_Valid), 0);
    chk("rst_cnt",   64'(o_Stall_Cnt), 0);

    // plain capture of a load
    i_RSTn = 1;
    drive(LW, 10'h300);
    i_Read_Reg_Data1 = 32'h100; i_Read_Reg_Data2 = 32'h55; i_PC_Plus4 = 32'h1004;
    cyc();
    chk("pass_valid", 64'(o_EX_Valid), 1);
    chk("pass_rs",    64'(o_EX_Rs), 4);
    chk("pass_rt",    64'(o_EX_Rt), 5);
    chk("pass_imm",   64'(o_EX_Imm), 4);
    chk("pass_d1",    64'(o_EX_Read_Data1), 32'h100);

    // load-use: one bubble then capture
    drive(ADD, 10'h200);
    #1 chk("lu_stall", 64'(o_Stall), 1);
    cyc();
    chk("lu_bubble", 64'(o_EX_Valid), 0);
    chk("lu_cnt",    64'(o_Stall_Cnt), 1);
    chk("lu_stall2", 64'(o_Stall), 0);
    cyc();
    chk("lu_valid", 64'(o_EX_Valid), 1);
    chk("lu_rd",    64'(o_EX_Rd), 6);

    // WB bypass beats stale register-file data; r0 never bypasses
    i_WB_RegWrite = 1; i_WB_Write_Reg_Addr = 7; i_WB_Write_Reg_Data = 32'hDEADBEEF;
    i_Read_Reg_Data2 = 32'h1;
    cyc();
    chk("byp_d2", 64'(o_EX_Read_Data2), 32'hDEADBEEF);
    drive(ADD0, 10'h200);
    i_WB_Write_Reg_Addr = 0; i_WB_Write_Reg_Data = 32'hFFFF; i_Read_Reg_Data2 = 32'h1234;
    cyc();
    chk("r0_d2", 64'(o_EX_Read_Data2), 0);
    i_WB_RegWrite = 0;

    // flush coincident with hazard
    drive(LW, 10'h300);
    cyc();
    drive(ADD, 10'h200);
    i_Flush = 1;
    #1 chk("fl_stall", 64'(o_Stall), 0);
    cyc();
    chk("fl_valid", 64'(o_EX_Valid), 0);
    chk("fl_cnt",   64'(o_Stall_Cnt), 1);
    i_Flush = 0;

    // saturation: preset counter near the top
    #2;
    force dut.stall_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1 release dut.stall_cnt;
    cyc();
    drive(LW, 10'h300); cyc();
    drive(ADD, 10'h200); cyc();
    chk("sat_cnt1", 64'(o_Stall_Cnt), 16'hFFFF);
    cyc();
    drive(LW, 10'h300); cyc();
    drive(ADD, 10'h200); cyc();
    chk("sat_cnt2", 64'(o_Stall_Cnt), 16'hFFFF);
    cyc();

    // reset taken while the bubble is in flight
    drive(LW, 10'h300); cyc();
    drive(ADD, 10'h200); cyc();
    i_RSTn = 0;
    cyc();
    chk("rb_valid", 64'(o_EX_Valid), 0);
    chk("rb_cnt",   64'(o_Stall_Cnt), 0);
    chk("rb_regs",  64'({o_EX_Ctrl, o_EX_Rs, o_EX_Rt, o_EX_Imm}), 0);
    i_RSTn = 1;
    #1 chk("rb_stall", 64'(o_Stall), 0);
    cyc();
    chk("rb_cap", 64'(o_EX_Valid), 1);
    chk("rb_rd",  64'(o_EX_Rd), 6);

    // randomized traffic with a small register set so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      i_Instr  = ins;
      i_Ctrl   = 10'($urandom);
      i_Ctrl[8] = ($urandom_range(0, 1) == 1);
      i_RSTn   = ($urandom_range(0, 199) != 0);
      i_Valid  = ($urandom_range(0, 7) != 0);
      i_Flush  = ($urandom_range(0, 9) == 0);
      i_PC_Plus4 = $urandom;
      i_Read_Reg_Data1 = $urandom;
      i_Read_Reg_Data2 = $urandom;
      i_WB_RegWrite = ($urandom_range(0, 1) == 1);
      i_WB_Write_Reg_Addr = 5'($urandom_range(0, 7));
      i_WB_Write_Reg_Data = $urandom;
      cyc();
    end

    @(posedge i_CLK);
    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
